// File: rtl/line_fill_responder.sv
// Cache line refill responder: reads one line from a synchronous RAM a word at a
// time and returns it as a beat burst through a 2-entry output buffer.
module line_fill_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int BEATS     = 8,
  parameter int LATENCY   = 2,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [63:0]   req_addr,
  output logic          req_ready,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [63:0]   rsp_data,
  output logic          rsp_last,
  output logic          rsp_err,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [63:0]   mem_rdata
);
  localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DRAIN} state_e;

  state_e        state_q;
  logic [AW-1:0] base_q;
  logic          err_q;
  logic [15:0]   wcnt_q;
  logic [KW-1:0] k_q;
  logic          inf_q, inf_last_q, inf_err_q;
  logic [63:0]   dat_q  [2];
  logic          last_q [2];
  logic          errb_q [2];
  logic          rd_q, wr_q;
  logic [1:0]    cnt_q;

  logic pop, push, issue, k_last;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[2:0];

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (cnt_q != 2'd0);
  assign rsp_data  = dat_q[rd_q];
  assign rsp_last  = last_q[rd_q];
  assign rsp_err   = errb_q[rd_q];

  assign pop    = rsp_valid && rsp_ready;
  assign push   = inf_q;
  assign k_last = (k_q == KW'(BEATS - 1));
  // A slot is free once buffered + in-flight beats, net of this cycle's pop, is below 2.
  assign issue    = (state_q == BURST) &&
                    (({1'b0, cnt_q} + {2'b00, inf_q}) < (3'd2 + {2'b00, pop}));
  assign mem_rd   = issue && !err_q;
  assign mem_addr = mem_rd ? (base_q + AW'(k_q)) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      err_q      <= 1'b0;
      wcnt_q     <= '0;
      k_q        <= '0;
      inf_q      <= 1'b0;
      inf_last_q <= 1'b0;
      inf_err_q  <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < 2; i++) begin
        dat_q[i]  <= '0;
        last_q[i] <= 1'b0;
        errb_q[i] <= 1'b0;
      end
    end else begin
      inf_q      <= issue;
      inf_last_q <= issue && k_last;
      inf_err_q  <= err_q;
      // Error beats never touch the RAM but reuse the same slot timing.
      if (push) begin
        dat_q[wr_q]  <= inf_err_q ? 64'h0 : mem_rdata;
        last_q[wr_q] <= inf_last_q;
        errb_q[wr_q] <= inf_err_q;
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);

      case (state_q)
        IDLE: if (req_valid) begin
          base_q  <= req_addr[AW+2:3] & ~AW'(BEATS - 1);
          err_q   <= (req_addr[63:3] >= 61'(MEM_WORDS));
          k_q     <= '0;
          wcnt_q  <= 16'(LATENCY);
          state_q <= (LATENCY == 0) ? BURST : WAIT;
        end
        WAIT: begin
          if (wcnt_q <= 16'd1) state_q <= BURST;
          else                 wcnt_q  <= wcnt_q - 16'd1;
        end
        BURST: if (issue) begin
          k_q <= k_q + KW'(1);
          if (k_last) state_q <= DRAIN;
        end
        DRAIN: if (pop && rsp_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !pop && cnt_q == 2'd2));
  end
endmodule

// File: tb/tb_line_fill_responder.sv
// Bench for line_fill_responder: directed and randomized line requests checked
// against a queue of expected beats derived from the line address.
module tb_line_fill_responder;
  localparam int MW = 4096, BEATS = 8, LAT = 2, AW = 12;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, rsp_ready = 1'b1;
  logic [63:0] req_addr = '0, rsp_data, mem_rdata = '0;
  logic req_ready, rsp_valid, rsp_last, rsp_err, mem_rd;
  logic [AW-1:0] mem_addr;

  logic z_req_valid = 1'b0, z_rsp_ready = 1'b1;
  logic [63:0] z_req_addr = '0, z_rsp_data, z_mem_rdata = '0;
  logic z_req_ready, z_rsp_valid, z_rsp_last, z_rsp_err, z_mem_rd;
  logic [AW-1:0] z_mem_addr;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  line_fill_responder #(.MEM_WORDS(MW), .BEATS(BEATS), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rsp_err(rsp_err), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata));

  line_fill_responder #(.MEM_WORDS(MW), .BEATS(BEATS), .LATENCY(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_addr(z_req_addr), .req_ready(z_req_ready),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_data(z_rsp_data), .rsp_last(z_rsp_last),
    .rsp_err(z_rsp_err), .mem_rd(z_mem_rd), .mem_addr(z_mem_addr), .mem_rdata(z_mem_rdata));

  function automatic logic [63:0] word(input longint unsigned i);
    return i * 64'h0101010101010101;
  endfunction

  always @(posedge clk) begin
    if (mem_rd)   mem_rdata   <= word(longint'(mem_addr));
    if (z_mem_rd) z_mem_rdata <= word(longint'(z_mem_addr));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the edge, outputs sampled 1 unit later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_req(input logic [63:0] addr, input int mode, input bit timed);
    logic [63:0] exp_d[$];
    bit   exp_e, done;
    int   base, nissue, npop, nrd, cyc, first, last;
    logic pv, pr, pl, pe;
    logic [63:0] pd;
    exp_e = (addr >> 3) >= 64'(MW);
    base  = int'(addr >> 6) * 8;
    for (int j = 0; j < BEATS; j++) exp_d.push_back(exp_e ? 64'h0 : word(longint'(base + j)));
    nissue = 0; npop = 0; nrd = 0; cyc = 0; first = -1; last = -1; done = 1'b0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pe = 1'b0; pd = '0;
    tick(); req_valid = 1'b1; req_addr = addr; rsp_ready = 1'b1; #1;
    chk("accept_ready", req_ready, 1'b1);
    while (!done && cyc < 300) begin
      tick(); cyc++;
      req_valid = 1'b0;
      req_addr  = {$urandom, $urandom};
      case (mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (pv && !pr) begin
        chk("stall_valid", rsp_valid, 1'b1);
        chk("stall_data", rsp_data, pd);
        chk("stall_last", rsp_last, pl);
        chk("stall_err", rsp_err, pe);
      end
      if (mem_rd) begin
        nrd++;
        chk("issue_slots", 64'((nissue - npop - int'(rsp_valid && rsp_ready)) < 2), 1);
        chk("mem_addr", mem_addr, 64'(base + nissue));
        if (timed && nissue == 0) chk("first_rd_cycle", cyc, 1 + LAT);
        nissue++;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_d.size() == 0) chk("extra_beat", 1, 0);
        else begin
          chk("beat_data", rsp_data, exp_d.pop_front());
          chk("beat_err", rsp_err, exp_e);
          chk("beat_last", rsp_last, npop == BEATS - 1);
        end
        if (npop == 0) first = cyc;
        npop++;
        if (npop == BEATS) begin last = cyc; done = 1'b1; end
      end
      pv = rsp_valid; pr = rsp_ready; pd = rsp_data; pl = rsp_last; pe = rsp_err;
    end
    if (!done) chk("burst_timeout", npop, BEATS);
    chk("rd_count", nrd, exp_e ? 0 : BEATS);
    if (timed) begin
      chk("first_beat_cycle", first, 3 + LAT);
      chk("last_beat_cycle", last, 2 + LAT + BEATS);
    end
    tick(); rsp_ready = 1'b1; #1;
    chk("idle_ready", req_ready, 1'b1);
    chk("idle_no_beat", rsp_valid, 1'b0);
  endtask

  initial begin
    int npop, cyc, firstrd, first, last1, acc2;
    // reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_last", rsp_last, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_data", rsp_data, 64'h0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'h0);

    run_req(64'h1048, 0, 1'b1);
    run_req(64'h1048, 1, 1'b0);
    run_req(64'h8000, 0, 1'b1);
    run_req(64'h7FC0, 0, 1'b1);

    // reset mid-burst with two beats buffered
    tick(); req_valid = 1'b1; req_addr = 64'h1048; rsp_ready = 1'b1; #1;
    npop = 0; cyc = 0;
    while (npop < 3 && cyc < 50) begin
      tick(); cyc++; req_valid = 1'b0; rsp_ready = 1'b1; #1;
      if (rsp_valid && rsp_ready) npop++;
    end
    chk("rst_pre_pops", npop, 3);
    repeat (3) begin tick(); rsp_ready = 1'b0; #1; end
    chk("rst_pre_valid", rsp_valid, 1'b1);
    tick(); rst = 1'b1; #1;
    tick(); rst = 1'b0; rsp_ready = 1'b1; #1;
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_mem_rd", mem_rd, 1'b0);
    run_req(64'h40, 0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 4) == 0) run_req(64'h8000 + 64'($urandom_range(0, 65535)), 2, 1'b0);
      else                           run_req(64'($urandom_range(0, 32767)), 2, 1'b0);
    end

    // zero-latency instance: request held valid across the burst
    tick(); z_req_valid = 1'b1; z_req_addr = 64'h0; z_rsp_ready = 1'b1; #1;
    chk("z_accept", z_req_ready, 1'b1);
    npop = 0; cyc = 0; firstrd = -1; first = -1; last1 = -1; acc2 = -1;
    while (npop < 2 * BEATS && cyc < 100) begin
      tick(); cyc++;
      z_req_valid = (acc2 < 0);
      z_req_addr  = 64'h40;
      #1;
      if (z_mem_rd && firstrd < 0) firstrd = cyc;
      if (z_req_valid && z_req_ready && acc2 < 0) acc2 = cyc;
      if (z_rsp_valid && z_rsp_ready) begin
        chk("z_beat_data", z_rsp_data, word(longint'(npop)));
        chk("z_beat_last", z_rsp_last, (npop % BEATS) == BEATS - 1);
        if (npop == 0) first = cyc;
        if (npop == BEATS - 1) last1 = cyc;
        npop++;
      end
    end
    z_req_valid = 1'b0;
    chk("z_beats", npop, 2 * BEATS);
    chk("z_first_rd", firstrd, 1);
    chk("z_first_beat", first, 3);
    chk("z_last_beat", last1, 2 + BEATS);
    chk("z_second_accept", acc2, 3 + BEATS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
